btn_debounce: RTL and testbench
===============================

# btn_debounce

Button conditioning stage for the cursor-control path: synchronizes raw push-button inputs into `clk`, rejects contact bounce with a per-button stability counter, and presents clean active-high level signals. Its `btn_level` outputs feed the downstream rising-edge one-pulse stage, which turns each debounced press into a single-cycle cursor command.

## Interface
- `NUM_BTN`, default 5: number of buttons (up, down, left, right, select).
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles an input must hold a new value before the output follows (10 ms at 50 MHz). Must be >= 2.
- `ACTIVE_LOW_IN`, default 1: 1 means the raw input reads 0 when pressed; 0 means it reads 1 when pressed.

Ports:
- `clk`  input  1  system clock, rising edge only.
- `rst_n`  input  1  asynchronous, active-low reset.
- `btn_raw`  input  NUM_BTN  raw asynchronous button pins, polarity per `ACTIVE_LOW_IN`.
- `btn_level`  output  NUM_BTN  debounced level, active-high (1 = pressed), registered.
- `btn_any`  output  1  OR of all `btn_level` bits.

## Operation
- Each bit is handled independently by an identical lane: sync, normalize, count, update.
- **Sync:** two-flop synchronizer per bit (`sync1` then `sync2`). Reset value is the "released" pin level: 1 if `ACTIVE_LOW_IN`, else 0.
- **Normalize:** `norm = sync2 ^ ACTIVE_LOW_IN`, so pressed reads 1.
- **Counter:** width is `$clog2(DEBOUNCE_CYCLES)`, resets to 0.
  - If `norm == btn_level`: counter clears to 0.
  - Else, if counter < `DEBOUNCE_CYCLES-1`: counter increments.
  - Else (counter == `DEBOUNCE_CYCLES-1` and still mismatched): `btn_level` takes `norm` and the counter clears to 0.
- Any return to agreement before terminal count discards progress, so a glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches the output.
- The counter never wraps; it saturates at terminal count and the update clears it.
- Press and release are debounced symmetrically.
- `btn_any` is combinational from the registered `btn_level`.
- **Reset:** asserting `rst_n` at any time, including mid-count, returns all state to reset values. Nothing is remembered.

## Timing
- Reset values: `btn_level` = 0, `btn_any` = 0, counters = 0, sync flops = released level.
- Latency: let edge 0 be the first edge at which `sync1` captures a new, then-stable raw value.
  - `sync2` updates at edge 1.
  - Counter reaches `DEBOUNCE_CYCLES-1` at edge `DEBOUNCE_CYCLES`.
  - `btn_level` changes at edge `DEBOUNCE_CYCLES+1`.
- `btn_level` changes at most once per `DEBOUNCE_CYCLES` cycles per bit.
- Simultaneous changes on several bits are processed in parallel with identical latency; there is no cross-bit interaction.
- A raw change during reset is sampled fresh after `rst_n` deasserts. The count starts from 0 at the first post-reset edge.
- There is no handshake. The consumer samples the level every cycle.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=8, `NUM_BTN`=5, `ACTIVE_LOW_IN`=1.
- **Reset values:** hold `rst_n`=0 with `btn_raw`=5'b11110 → `btn_level`=0, `btn_any`=0 throughout. Release reset → `btn_level[0]` rises 9 edges after the first post-reset sampling edge.
- **Clean press/release:** drive `btn_raw[0]` 1→0 and hold → `btn_level[0]`=1 at edge 9, 0 at edges 0–8. Then drive it 0→1 → `btn_level[0]` falls 9 edges later, and `btn_any` tracks both transitions.
- **Glitch threshold:** low pulse of 7 cycles on `btn_raw[2]` → `btn_level[2]` stays 0. Low pulse of exactly 8 cycles → `btn_level[2]` goes 1.
- **Bounce burst:** `btn_raw[1]` toggles every 3 cycles for 30 cycles, then holds 0 → exactly one 0→1 transition, 9 edges after the final settle.
- **Independence:** press `btn_raw[3]` at cycle 0 and `btn_raw[4]` at cycle 3 → `btn_level[3]` and `btn_level[4]` rise 3 cycles apart, with no effect on other bits.
- **Reset mid-count:** press `btn_raw[0]`, assert `rst_n`=0 after 5 cycles with the input still held → `btn_level`=0 immediately. After deassertion, a full 9-edge latency applies again.

Source files
------------

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, polarity normalize and a
// per-button stability counter producing clean active-high levels.
module btn_debounce #(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW_IN   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               btn_any
);

  localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Pin level of a released button; also the synchronizer reset value.
  localparam logic [NUM_BTN-1:0] REL_LVL = {NUM_BTN{ACTIVE_LOW_IN}};

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] norm;
  logic [NUM_BTN-1:0] level_nxt;
  logic [CNT_W-1:0]   cnt     [NUM_BTN];
  logic [CNT_W-1:0]   cnt_nxt [NUM_BTN];

  // Two-flop synchronizer on the raw pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= REL_LVL;
      sync2 <= REL_LVL;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign norm = sync2 ^ REL_LVL;

  // Per-lane stability counter: any agreement discards progress, terminal
  // count with a persisting mismatch commits the new level.
  always_comb begin
    level_nxt = btn_level;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      cnt_nxt[i] = '0;
      if (norm[i] != btn_level[i]) begin
        if (cnt[i] < CNT_TERM) begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end else begin
          level_nxt[i] = norm[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level <= '0;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      btn_level <= level_nxt;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign btn_any = |btn_level;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=8, five active-low buttons.
module tb_btn_debounce;

  localparam int unsigned NB = 5;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic          btn_any;

  int tests;
  int fails;

  btn_debounce #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(8),
    .ACTIVE_LOW_IN  (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_any  (btn_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_vec(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    btn_raw = 5'b11110;

    // Reset holds outputs low even with button 0 pressed
    tick(3);
    chk_vec("rst_level", btn_level, 5'b00000);
    chk_bit("rst_any", btn_any, 1'b0);
    rst_n = 1'b1;
    tick(9);
    chk_vec("rst_rel_edge8", btn_level, 5'b00000);
    tick(1);
    chk_vec("rst_rel_edge9", btn_level, 5'b00001);
    chk_bit("rst_rel_any", btn_any, 1'b1);

    // Clean release then clean press on bit 0
    btn_raw[0] = 1'b1;
    tick(9);
    chk_vec("release_edge8", btn_level, 5'b00001);
    tick(1);
    chk_vec("release_edge9", btn_level, 5'b00000);
    chk_bit("release_any", btn_any, 1'b0);
    tick(3);
    btn_raw[0] = 1'b0;
    tick(1);
    chk_vec("press_edge0", btn_level, 5'b00000);
    tick(8);
    chk_vec("press_edge8", btn_level, 5'b00000);
    chk_bit("press_any_lo", btn_any, 1'b0);
    tick(1);
    chk_vec("press_edge9", btn_level, 5'b00001);
    chk_bit("press_any_hi", btn_any, 1'b1);
    btn_raw[0] = 1'b1;
    tick(12);
    chk_vec("press_settle", btn_level, 5'b00000);

    // 7-cycle glitch on bit 2 must be rejected
    btn_raw[2] = 1'b0;
    tick(7);
    btn_raw[2] = 1'b1;
    tick(3);
    chk_bit("glitch7_mid", btn_level[2], 1'b0);
    tick(10);
    chk_vec("glitch7_end", btn_level, 5'b00000);

    // 8-cycle pulse on bit 2 just passes
    btn_raw[2] = 1'b0;
    tick(8);
    btn_raw[2] = 1'b1;
    tick(1);
    chk_bit("pulse8_edge8", btn_level[2], 1'b0);
    tick(1);
    chk_vec("pulse8_edge9", btn_level, 5'b00100);
    tick(7);
    chk_vec("pulse8_hold", btn_level, 5'b00100);
    tick(2);
    chk_vec("pulse8_released", btn_level, 5'b00000);

    // Bounce burst on bit 1: 3-cycle toggles, then settle low
    for (int s = 0; s < 10; s++) begin
      btn_raw[1] = (s % 2 == 1);
      for (int c = 0; c < 3; c++) begin
        tick(1);
        chk_bit("bounce_quiet", btn_level[1], 1'b0);
      end
    end
    btn_raw[1] = 1'b0;
    tick(9);
    chk_vec("bounce_edge8", btn_level, 5'b00000);
    tick(1);
    chk_vec("bounce_edge9", btn_level, 5'b00010);
    tick(20);
    chk_vec("bounce_stable", btn_level, 5'b00010);
    btn_raw[1] = 1'b1;
    tick(12);
    chk_vec("bounce_released", btn_level, 5'b00000);

    // Independence: bit 3 then bit 4 three cycles later
    btn_raw[3] = 1'b0;
    tick(3);
    btn_raw[4] = 1'b0;
    tick(6);
    chk_vec("indep_edge8", btn_level, 5'b00000);
    tick(1);
    chk_vec("indep_b3", btn_level, 5'b01000);
    tick(2);
    chk_vec("indep_b4_pre", btn_level, 5'b01000);
    tick(1);
    chk_vec("indep_both", btn_level, 5'b11000);
    btn_raw[4] = 1'b1;
    tick(12);
    chk_vec("indep_b4_rel", btn_level, 5'b01000);

    // Reset mid-count on bit 0 while bit 3 is held pressed
    btn_raw[0] = 1'b0;
    tick(5);
    rst_n = 1'b0;
    #1;
    chk_vec("midrst_clear", btn_level, 5'b00000);
    chk_bit("midrst_any", btn_any, 1'b0);
    tick(3);
    chk_vec("midrst_hold", btn_level, 5'b00000);
    rst_n = 1'b1;
    tick(9);
    chk_vec("midrst_edge8", btn_level, 5'b00000);
    tick(1);
    chk_vec("midrst_edge9", btn_level, 5'b01001);
    chk_bit("midrst_any_hi", btn_any, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
